// File: rtl/sync_pkt_fifo.sv
// sync_pkt_fifo: single-clock frame FIFO with commit/discard write semantics.
// Words written since the last commit are invisible to the reader until
// wr_commit publishes them; wr_discard (or a commit after an overflow) rolls
// the write pointer back to the last commit point, so a bad frame never
// reaches the read side.
//
// Build option:
//   SYNC_PKT_FIFO_FWFT_EN  defined   -> first-word fall-through read port
//                          undefined -> registered read (dout/rd_ack one
//                                       cycle after an accepted rd_en)

module sync_pkt_fifo #(
    parameter int DATA_WIDTH         = 16,
    parameter int ADDR_WIDTH         = 8,
    parameter int ALMOST_FULL_DEPTH  = 240,
    parameter int ALMOST_EMPTY_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // write side
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    input  logic                  wr_commit,
    input  logic                  wr_discard,
    output logic                  full,
    output logic                  almost_full,
    output logic                  wr_ovf,
    output logic [ADDR_WIDTH:0]   wr_count,
    // read side
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_ack,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Pointers carry one extra bit so that "full" (difference == DEPTH) and
    // "empty" (difference == 0) are distinguishable with plain subtraction.
    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t        PTR_ONE = ptr_t'(1);
    localparam ptr_t        DEPTH_P = ptr_t'(DEPTH);
    localparam logic [31:0] AF_TH   = ALMOST_FULL_DEPTH;
    localparam logic [31:0] AE_TH   = ALMOST_EMPTY_DEPTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ptr_t wr_ptr_q,     wr_ptr_d;
    ptr_t commit_ptr_q, commit_ptr_d;
    ptr_t rd_ptr_q,     rd_ptr_d;
    logic wr_ovf_q,     wr_ovf_d;

    logic ovf_now;
    logic rollback;
    logic wr_accept;
    logic rd_accept;

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    // Status decodes depend only on registered pointers, never on inputs.
    assign wr_count     = wr_ptr_q - rd_ptr_q;
    assign rd_count     = commit_ptr_q - rd_ptr_q;
    assign full         = (wr_count == DEPTH_P);
    assign empty        = (rd_count == '0);
    assign almost_full  = (32'(wr_count) >= AF_TH);
    assign almost_empty = (32'(rd_count) <= AE_TH);
    assign wr_ovf       = wr_ovf_q;

    // Write side: accept, commit, rollback and sticky overflow tracking.
    always_comb begin
        ovf_now      = wr_en && full;
        // A commit of a frame that lost a word is no better than a discard.
        rollback     = wr_discard || (wr_commit && (wr_ovf_q || ovf_now));
        wr_accept    = wr_en && !full && !rollback;

        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wr_ovf_d     = wr_ovf_q;

        if (rollback) begin
            wr_ptr_d = commit_ptr_q;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            // Commit includes the word accepted in this same cycle.
            if (wr_commit) begin
                commit_ptr_d = wr_ptr_d;
            end
        end

        // Any frame boundary clears the overflow flag; otherwise it sticks.
        if (wr_commit || wr_discard) begin
            wr_ovf_d = 1'b0;
        end else if (ovf_now) begin
            wr_ovf_d = 1'b1;
        end
    end

    // Read side: pop one committed word per accepted rd_en.
    always_comb begin
        rd_accept = rd_en && !empty;
        rd_ptr_d  = rd_ptr_q;
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer and overflow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            wr_ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ovf_q     <= wr_ovf_d;
        end
    end

    // Storage array; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_addr] <= din;
        end
    end

    // A write never targets the word being read: a write needs !full and a
    // read needs !empty, and the two addresses only alias in those states.

`ifdef SYNC_PKT_FIFO_FWFT_EN

    // Head word falls through; dout is forced to 0 while nothing is visible.
    assign dout   = empty ? '0 : mem[rd_addr];
    assign rd_ack = !empty;

`else

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  rd_ack_q, rd_ack_d;

    // Registered read: capture the head word on an accepted read, else hold.
    always_comb begin
        dout_d   = dout_q;
        rd_ack_d = rd_accept;
        if (rd_accept) begin
            dout_d = mem[rd_addr];
        end
    end

    // Read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q   <= '0;
            rd_ack_q <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            rd_ack_q <= rd_ack_d;
        end
    end

    assign dout   = dout_q;
    assign rd_ack = rd_ack_q;

`endif

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Bench for sync_pkt_fifo: a default-size instance checked against a
// queue-based frame model, plus a 16-deep instance for the overflow corner.

module tb_sync_pkt_fifo;

    localparam int DW      = 16;
    localparam int AW      = 8;
    localparam int DEPTH   = 256;
    localparam int AF      = 240;
    localparam int AE      = 4;
    localparam int S_AW    = 4;
    localparam int S_DEPTH = 16;
    localparam int S_AF    = 12;
    localparam int S_AE    = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic          rst_n, wr_en, wr_commit, wr_discard, rd_en;
    logic [DW-1:0] din, dout;
    logic          full, almost_full, wr_ovf, rd_ack, empty, almost_empty;
    logic [AW:0]   wr_count, rd_count;

    // small instance
    logic            s_rst_n, s_wr_en, s_wr_commit, s_wr_discard, s_rd_en;
    logic [DW-1:0]   s_din, s_dout;
    logic            s_full, s_almost_full, s_wr_ovf, s_rd_ack, s_empty, s_almost_empty;
    logic [S_AW:0]   s_wr_count, s_rd_count;

    sync_pkt_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ALMOST_FULL_DEPTH(AF), .ALMOST_EMPTY_DEPTH(AE)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en),
        .wr_commit(wr_commit), .wr_discard(wr_discard), .full(full),
        .almost_full(almost_full), .wr_ovf(wr_ovf), .wr_count(wr_count),
        .rd_en(rd_en), .dout(dout), .rd_ack(rd_ack), .empty(empty),
        .almost_empty(almost_empty), .rd_count(rd_count)
    );

    sync_pkt_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(S_AW),
        .ALMOST_FULL_DEPTH(S_AF), .ALMOST_EMPTY_DEPTH(S_AE)
    ) u_small (
        .clk(clk), .rst_n(s_rst_n), .din(s_din), .wr_en(s_wr_en),
        .wr_commit(s_wr_commit), .wr_discard(s_wr_discard), .full(s_full),
        .almost_full(s_almost_full), .wr_ovf(s_wr_ovf), .wr_count(s_wr_count),
        .rd_en(s_rd_en), .dout(s_dout), .rd_ack(s_rd_ack), .empty(s_empty),
        .almost_empty(s_almost_empty), .rd_count(s_rd_count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: committed-unread words and the open frame, as queues.
    logic [DW-1:0] cq[$];
    logic [DW-1:0] pq[$];
    bit            m_ovf;
    logic [DW-1:0] m_dout;
    bit            m_ack;

    task automatic model_reset();
        cq.delete();
        pq.delete();
        m_ovf  = 1'b0;
        m_dout = '0;
        m_ack  = 1'b0;
    endtask

    // Drive one cycle on the main instance and advance the model alongside.
    task automatic step(input bit we, input logic [DW-1:0] d, input bit cm,
                        input bit dc, input bit re);
        bit mfull, mempty, ovf_now, rb;
        wr_en = we; din = d; wr_commit = cm; wr_discard = dc; rd_en = re;
        mfull  = (cq.size() + pq.size() == DEPTH);
        mempty = (cq.size() == 0);
`ifdef SYNC_PKT_FIFO_FWFT_EN
        if (re && !mempty) cq.delete(0);
`else
        if (re && !mempty) begin
            m_dout = cq.pop_front();
            m_ack  = 1'b1;
        end else begin
            m_ack = 1'b0;
        end
`endif
        ovf_now = we && mfull;
        rb      = dc || (cm && (m_ovf || ovf_now));
        if (!rb && we && !mfull) pq.push_back(d);
        if (rb) begin
            pq.delete();
        end else if (cm) begin
            foreach (pq[i]) cq.push_back(pq[i]);
            pq.delete();
        end
        if (cm || dc) m_ovf = 1'b0;
        else if (ovf_now) m_ovf = 1'b1;
`ifdef SYNC_PKT_FIFO_FWFT_EN
        m_ack = (cq.size() != 0);
        if (m_ack) m_dout = cq[0];
`endif
        @(posedge clk);
        #1;
        wr_en = 1'b0; wr_commit = 1'b0; wr_discard = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_rst_n = 1'b0;
        repeat (3) begin
            wr_en = 1'($urandom); wr_commit = 1'($urandom); rd_en = 1'($urandom);
            din = 16'($urandom);
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0; wr_commit = 1'b0; rd_en = 1'b0;
        checks++;
        if ({empty, almost_empty, full, almost_full, wr_ovf, rd_ack} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=110000",
                     {empty, almost_empty, full, almost_full, wr_ovf, rd_ack});
        end
        checks++;
        if (wr_count !== '0 || rd_count !== '0) begin
            failures++;
            $display("FAIL reset_counts got wc=%0d rc=%0d exp 0/0", wr_count, rd_count);
        end
        checks++;
        if (dout !== '0) begin
            failures++;
            $display("FAIL reset_dout got=%h exp=0", dout);
        end
        checks++;
        if ({s_empty, s_full, s_wr_count} !== {1'b1, 1'b0, 5'd0}) begin
            failures++;
            $display("FAIL reset_small got empty=%b full=%b wc=%0d", s_empty, s_full, s_wr_count);
        end
        rst_n = 1'b1; s_rst_n = 1'b1;
        model_reset();
        repeat (3) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        checks++;
        if (wr_count !== 9'd3 || rd_count !== 9'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL uncommitted_hidden got wc=%0d rc=%0d empty=%b exp 3/0/1",
                     wr_count, rd_count, empty);
        end
    endtask

    task automatic test_commit_read();
        logic [DW-1:0] w [3];
        w[0] = 16'hA1A1; w[1] = 16'hB2B2; w[2] = 16'hC3C3;
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (wr_count !== 9'd0) begin
            failures++;
            $display("FAIL discard_leftover got wc=%0d exp=0", wr_count);
        end
        step(1'b1, w[0], 1'b0, 1'b0, 1'b0);
        step(1'b1, w[1], 1'b0, 1'b0, 1'b0);
        step(1'b1, w[2], 1'b1, 1'b0, 1'b0);
        checks++;
        if (rd_count !== 9'd3 || empty !== 1'b0 || almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL commit_visible got rc=%0d empty=%b ae=%b exp 3/0/1",
                     rd_count, empty, almost_empty);
        end
        for (int i = 0; i < 3; i++) begin
`ifdef SYNC_PKT_FIFO_FWFT_EN
            checks++;
            if (rd_ack !== 1'b1 || dout !== w[i]) begin
                failures++;
                $display("FAIL commit_read%0d got ack=%b dout=%h exp 1/%h", i, rd_ack, dout, w[i]);
            end
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
`else
            checks++;
            if (rd_ack !== 1'b0) begin
                failures++;
                $display("FAIL read_latency%0d got ack=%b before edge exp 0", i, rd_ack);
            end
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (rd_ack !== 1'b1 || dout !== w[i]) begin
                failures++;
                $display("FAIL commit_read%0d got ack=%b dout=%h exp 1/%h", i, rd_ack, dout, w[i]);
            end
            step(1'b0, '0, 1'b0, 1'b0, 1'b0);
`endif
        end
        checks++;
        if (empty !== 1'b1 || rd_count !== 9'd0) begin
            failures++;
            $display("FAIL drained got empty=%b rc=%0d exp 1/0", empty, rd_count);
        end
        // read while empty is ignored
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (rd_ack !== 1'b0 || rd_count !== 9'd0 || wr_count !== 9'd0) begin
            failures++;
            $display("FAIL read_empty got ack=%b rc=%0d wc=%0d exp 0/0/0", rd_ack, rd_count, wr_count);
        end
    endtask

    task automatic test_discard();
        logic [DW-1:0] w [2];
        w[0] = 16'h1234; w[1] = 16'h5678;
        step(1'b1, w[0], 1'b0, 1'b0, 1'b0);
        step(1'b1, w[1], 1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        checks++;
        if (wr_count !== 9'd7 || rd_count !== 9'd2) begin
            failures++;
            $display("FAIL discard_pre got wc=%0d rc=%0d exp 7/2", wr_count, rd_count);
        end
        // discard with a same-cycle write and commit: discard wins
        step(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
        checks++;
        if (wr_count !== 9'd2 || rd_count !== 9'd2) begin
            failures++;
            $display("FAIL discard_wins got wc=%0d rc=%0d exp 2/2", wr_count, rd_count);
        end
        for (int i = 0; i < 2; i++) begin
`ifdef SYNC_PKT_FIFO_FWFT_EN
            checks++;
            if (rd_ack !== 1'b1 || dout !== w[i]) begin
                failures++;
                $display("FAIL discard_read%0d got ack=%b dout=%h exp 1/%h", i, rd_ack, dout, w[i]);
            end
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
`else
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (rd_ack !== 1'b1 || dout !== w[i]) begin
                failures++;
                $display("FAIL discard_read%0d got ack=%b dout=%h exp 1/%h", i, rd_ack, dout, w[i]);
            end
`endif
        end
        checks++;
        if (empty !== 1'b1 || wr_count !== 9'd0) begin
            failures++;
            $display("FAIL discard_drained got empty=%b wc=%0d exp 1/0", empty, wr_count);
        end
    endtask

    task automatic test_overflow();
        s_wr_en = 1'b0; s_wr_commit = 1'b0; s_wr_discard = 1'b0; s_rd_en = 1'b0; s_din = '0;
        for (int i = 0; i < S_DEPTH; i++) begin
            s_wr_en = 1'b1; s_din = 16'(i);
            @(posedge clk);
            #1;
            checks++;
            if (s_full !== 1'(i == S_DEPTH - 1) || s_wr_count !== 5'(i + 1) ||
                s_almost_full !== 1'(i + 1 >= S_AF) || s_wr_ovf !== 1'b0) begin
                failures++;
                $display("FAIL ovf_fill%0d got full=%b af=%b wc=%0d ovf=%b", i,
                         s_full, s_almost_full, s_wr_count, s_wr_ovf);
            end
        end
        s_din = 16'hFFFF;
        @(posedge clk);
        #1;
        s_wr_en = 1'b0;
        checks++;
        if (s_wr_ovf !== 1'b1 || s_wr_count !== 5'd16 || s_full !== 1'b1 || s_empty !== 1'b1) begin
            failures++;
            $display("FAIL ovf_17th got ovf=%b wc=%0d full=%b empty=%b exp 1/16/1/1",
                     s_wr_ovf, s_wr_count, s_full, s_empty);
        end
        @(posedge clk);
        #1;
        checks++;
        if (s_wr_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got=%b exp=1", s_wr_ovf);
        end
        s_wr_commit = 1'b1;
        @(posedge clk);
        #1;
        s_wr_commit = 1'b0;
        checks++;
        if (s_rd_count !== 5'd0 || s_wr_count !== 5'd0 || s_wr_ovf !== 1'b0 || s_empty !== 1'b1) begin
            failures++;
            $display("FAIL ovf_commit got rc=%0d wc=%0d ovf=%b empty=%b exp 0/0/0/1",
                     s_rd_count, s_wr_count, s_wr_ovf, s_empty);
        end
        // a clean frame afterwards commits normally
        s_wr_en = 1'b1; s_din = 16'h00AA;
        @(posedge clk);
        #1;
        s_din = 16'h00BB; s_wr_commit = 1'b1;
        @(posedge clk);
        #1;
        s_wr_en = 1'b0; s_wr_commit = 1'b0;
        checks++;
        if (s_rd_count !== 5'd2 || s_almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL ovf_recover got rc=%0d ae=%b exp 2/1", s_rd_count, s_almost_empty);
        end
`ifdef SYNC_PKT_FIFO_FWFT_EN
        checks++;
        if (s_dout !== 16'h00AA || s_rd_ack !== 1'b1) begin
            failures++;
            $display("FAIL ovf_readback got ack=%b dout=%h exp 1/00aa", s_rd_ack, s_dout);
        end
`else
        s_rd_en = 1'b1;
        @(posedge clk);
        #1;
        s_rd_en = 1'b0;
        checks++;
        if (s_dout !== 16'h00AA || s_rd_ack !== 1'b1) begin
            failures++;
            $display("FAIL ovf_readback got ack=%b dout=%h exp 1/00aa", s_rd_ack, s_dout);
        end
`endif
    endtask

    task automatic test_random();
        bit seen_af1 = 0, seen_af0 = 0, seen_ae1 = 0, seen_ae0 = 0;
        int total, phase, written;
        bit we, re, cm, dc;
        logic [AW:0] exp_wc, exp_rc;
        written = 0;
        for (int cyc = 0; cyc < 2400; cyc++) begin
            phase = (cyc / 400) % 2;
            we = ($urandom_range(0, 99) < (phase != 0 ? 20 : 85));
            re = ($urandom_range(0, 99) < (phase != 0 ? 95 : 10));
            cm = ($urandom_range(0, 7) == 0);
            dc = ($urandom_range(0, 59) == 0);
            if (we && !full) written++;
            step(we, 16'($urandom), cm, dc, re);
            total  = cq.size() + pq.size();
            exp_wc = (AW+1)'(total);
            exp_rc = (AW+1)'(cq.size());
            checks++;
            if (wr_count !== exp_wc || rd_count !== exp_rc || total > DEPTH) begin
                failures++;
                $display("FAIL rnd_counts cyc=%0d got wc=%0d rc=%0d exp %0d/%0d",
                         cyc, wr_count, rd_count, exp_wc, exp_rc);
            end
            checks++;
            if ({full, empty, almost_full, almost_empty, wr_ovf, rd_ack} !==
                {1'(total == DEPTH), 1'(cq.size() == 0), 1'(total >= AF),
                 1'(cq.size() <= AE), m_ovf, m_ack}) begin
                failures++;
                $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", cyc,
                         {full, empty, almost_full, almost_empty, wr_ovf, rd_ack},
                         {1'(total == DEPTH), 1'(cq.size() == 0), 1'(total >= AF),
                          1'(cq.size() <= AE), m_ovf, m_ack});
            end
            if (m_ack) begin
                checks++;
                if (dout !== m_dout) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, dout, m_dout);
                end
            end
            if (almost_full)  seen_af1 = 1'b1; else seen_af0 = 1'b1;
            if (almost_empty) seen_ae1 = 1'b1; else seen_ae0 = 1'b1;
        end
        checks++;
        if ({seen_af1, seen_af0, seen_ae1, seen_ae0} !== 4'b1111 || written < 600) begin
            failures++;
            $display("FAIL rnd_coverage got af1/af0/ae1/ae0=%b words=%0d",
                     {seen_af1, seen_af0, seen_ae1, seen_ae0}, written);
        end
    endtask

    task automatic test_midframe_reset();
        logic [DW-1:0] w [4];
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0101, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h0202, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
        // pending read and write, reset lands mid-cycle
        rd_en = 1'b1; wr_en = 1'b1; din = 16'h7777;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({empty, almost_empty, full, almost_full, wr_ovf, rd_ack} !== 6'b110000 ||
            wr_count !== '0 || rd_count !== '0 || dout !== '0) begin
            failures++;
            $display("FAIL midreset got flags=%b wc=%0d rc=%0d dout=%h",
                     {empty, almost_empty, full, almost_full, wr_ovf, rd_ack},
                     wr_count, rd_count, dout);
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0; wr_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || wr_count !== '0 || rd_ack !== 1'b0) begin
            failures++;
            $display("FAIL midreset_hold got empty=%b wc=%0d ack=%b", empty, wr_count, rd_ack);
        end
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) w[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'(i == 3), 1'b0, 1'b0);
        checks++;
        if (rd_count !== 9'd4) begin
            failures++;
            $display("FAIL postreset_commit got rc=%0d exp=4", rd_count);
        end
        for (int i = 0; i < 4; i++) begin
`ifdef SYNC_PKT_FIFO_FWFT_EN
            checks++;
            if (dout !== w[i] || rd_ack !== 1'b1) begin
                failures++;
                $display("FAIL postreset_read%0d got ack=%b dout=%h exp 1/%h", i, rd_ack, dout, w[i]);
            end
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
`else
            step(1'b0, '0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (dout !== w[i] || rd_ack !== 1'b1) begin
                failures++;
                $display("FAIL postreset_read%0d got ack=%b dout=%h exp 1/%h", i, rd_ack, dout, w[i]);
            end
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_commit = 1'b0; wr_discard = 1'b0; rd_en = 1'b0; din = '0;
        s_rst_n = 1'b0; s_wr_en = 1'b0; s_wr_commit = 1'b0; s_wr_discard = 1'b0;
        s_rd_en = 1'b0; s_din = '0;
        model_reset();
        #1;
        test_reset();
        test_commit_read();
        test_discard();
        test_overflow();
        test_random();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
